// File: rtl/mult_wb_scheduler.sv
// Credit-based issue control, result FIFO and writeback arbiter for a 4-stage pipelined multiplier.
// Optional MULT_WB_BYPASS_EN lets a returning product skip an empty FIFO and compete for writeback.
module mult_wb_scheduler #(
   parameter int unsigned ARCH_BITS      = 32,
   parameter int unsigned OPCODE_BITS    = 7,
   parameter int unsigned ROB_IDX_BITS   = 4,
   parameter int unsigned REG_IDX_BITS   = 5,
   parameter int unsigned OPCODE_NOP     = 0,
   parameter int unsigned RES_FIFO_DEPTH = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clear,
   // Issue side
   input  logic                              issValid,
   output logic                              issReady,
   input  logic [OPCODE_BITS-1:0]            issOpcode,
   input  logic [ROB_IDX_BITS-1:0]           issRobIdx,
   input  logic [REG_IDX_BITS-1:0]           issDstReg,
   input  logic [ARCH_BITS-1:0]              issData1,
   input  logic [ARCH_BITS-1:0]              issData2,
   // Multiplier inputs
   output logic [OPCODE_BITS-1:0]            mulOpcode,
   output logic [ROB_IDX_BITS-1:0]           mulRobIdx,
   output logic [REG_IDX_BITS-1:0]           mulDstReg,
   output logic [ARCH_BITS-1:0]              mulData1,
   output logic [ARCH_BITS-1:0]              mulData2,
   output logic                              mulClear,
   // Multiplier outputs
   input  logic [OPCODE_BITS-1:0]            mulOpcodeRes,
   input  logic [ROB_IDX_BITS-1:0]           mulRobIdxRes,
   input  logic [REG_IDX_BITS-1:0]           mulDstRegRes,
   input  logic [ARCH_BITS-1:0]              mulResH,
   input  logic [ARCH_BITS-1:0]              mulResL,
   // ALU result
   input  logic                              aluValid,
   input  logic [ROB_IDX_BITS-1:0]           aluRobIdx,
   input  logic [REG_IDX_BITS-1:0]           aluDstReg,
   input  logic [ARCH_BITS-1:0]              aluData,
   output logic                              aluGrant,
   // Writeback bus
   output logic                              wbValid,
   output logic                              wbSrc,
   output logic [ROB_IDX_BITS-1:0]           wbRobIdx,
   output logic [REG_IDX_BITS-1:0]           wbDstReg,
   output logic [ARCH_BITS-1:0]              wbDataL,
   output logic [ARCH_BITS-1:0]              wbDataH,
   output logic [$clog2(RES_FIFO_DEPTH):0]   credits
);

   localparam int unsigned PtrBits = $clog2(RES_FIFO_DEPTH);
   localparam int unsigned CntBits = PtrBits + 1;
   localparam logic [OPCODE_BITS-1:0] Nop = OPCODE_BITS'(OPCODE_NOP);
   localparam logic [CntBits-1:0] FullCnt = CntBits'(RES_FIFO_DEPTH);

   logic [CntBits-1:0]      r_credits;
   logic [CntBits-1:0]      r_count;
   logic [PtrBits-1:0]      r_wr_ptr;
   logic [PtrBits-1:0]      r_rd_ptr;
   logic                    r_rr_ptr;

   logic [ROB_IDX_BITS-1:0] r_fifo_rob [RES_FIFO_DEPTH];
   logic [REG_IDX_BITS-1:0] r_fifo_dst [RES_FIFO_DEPTH];
   logic [ARCH_BITS-1:0]    r_fifo_h   [RES_FIFO_DEPTH];
   logic [ARCH_BITS-1:0]    r_fifo_l   [RES_FIFO_DEPTH];

   logic                    r_wb_valid;
   logic                    r_wb_src;
   logic [ROB_IDX_BITS-1:0] r_wb_rob;
   logic [REG_IDX_BITS-1:0] r_wb_dst;
   logic [ARCH_BITS-1:0]    r_wb_l;
   logic [ARCH_BITS-1:0]    r_wb_h;

   logic w_accept;
   logic w_ret_valid;
   logic w_fifo_empty;
   logic w_fifo_full;
   logic w_byp_req;
   logic w_mul_req;
   logic w_alu_req;
   logic w_contested;
   logic w_grant_mul;
   logic w_grant_alu;
   logic w_bypass;
   logic w_push;
   logic w_pop;

   // Issue side
   assign issReady  = !rst && !clear && (r_credits != '0);
   assign w_accept  = issValid && issReady;
   assign mulOpcode = w_accept ? issOpcode : Nop;
   assign mulRobIdx = issRobIdx;
   assign mulDstReg = issDstReg;
   assign mulData1  = issData1;
   assign mulData2  = issData2;
   assign mulClear  = clear;

   // Return side
   assign w_ret_valid  = (mulOpcodeRes != Nop);
   assign w_fifo_empty = (r_count == '0);
   assign w_fifo_full  = (r_count == FullCnt);

`ifdef MULT_WB_BYPASS_EN
   assign w_byp_req = w_ret_valid && w_fifo_empty;
`else
   assign w_byp_req = 1'b0;
`endif

   assign w_mul_req   = !w_fifo_empty || w_byp_req;
   assign w_alu_req   = aluValid;
   assign w_contested = w_mul_req && w_alu_req;

   // r_rr_ptr: 0 prefers ALU, 1 prefers MUL; a full FIFO with a product landing must drain first.
   always_comb begin
      w_grant_mul = 1'b0;
      w_grant_alu = 1'b0;
      if (!rst && !clear) begin
         if (w_mul_req && (!w_alu_req || r_rr_ptr || (w_fifo_full && w_ret_valid))) begin
            w_grant_mul = 1'b1;
         end else if (w_alu_req) begin
            w_grant_alu = 1'b1;
         end
      end
   end

   assign aluGrant = w_grant_alu;
   assign w_bypass = w_grant_mul && w_fifo_empty;
   assign w_pop    = w_grant_mul && !w_fifo_empty;
   assign w_push   = w_ret_valid && !w_bypass && !clear && !rst;

   // Result storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rob[r_wr_ptr] <= mulRobIdxRes;
         r_fifo_dst[r_wr_ptr] <= mulDstRegRes;
         r_fifo_h[r_wr_ptr]   <= mulResH;
         r_fifo_l[r_wr_ptr]   <= mulResL;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_credits  <= FullCnt;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_rr_ptr   <= 1'b0;
         r_wb_valid <= 1'b0;
         r_wb_src   <= 1'b0;
         r_wb_rob   <= '0;
         r_wb_dst   <= '0;
         r_wb_l     <= '0;
         r_wb_h     <= '0;
      end else if (clear) begin
         r_credits  <= FullCnt;
         r_count    <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_wb_valid <= 1'b0;
      end else begin
         r_credits <= r_credits - CntBits'(w_accept) + CntBits'(w_grant_mul);
         r_count   <= r_count + CntBits'(w_push) - CntBits'(w_pop);
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PtrBits'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PtrBits'(1);
         end
         // After a contested grant the loser gets priority next time.
         if (w_contested) begin
            r_rr_ptr <= w_grant_alu;
         end
         r_wb_valid <= w_grant_mul || w_grant_alu;
         r_wb_src   <= w_grant_mul;
         if (w_grant_mul && w_bypass) begin
            r_wb_rob <= mulRobIdxRes;
            r_wb_dst <= mulDstRegRes;
            r_wb_l   <= mulResL;
            r_wb_h   <= mulResH;
         end else if (w_grant_mul) begin
            r_wb_rob <= r_fifo_rob[r_rd_ptr];
            r_wb_dst <= r_fifo_dst[r_rd_ptr];
            r_wb_l   <= r_fifo_l[r_rd_ptr];
            r_wb_h   <= r_fifo_h[r_rd_ptr];
         end else if (w_grant_alu) begin
            r_wb_rob <= aluRobIdx;
            r_wb_dst <= aluDstReg;
            r_wb_l   <= aluData;
            r_wb_h   <= '0;
         end
      end
   end

   assign wbValid  = r_wb_valid;
   assign wbSrc    = r_wb_src;
   assign wbRobIdx = r_wb_rob;
   assign wbDstReg = r_wb_dst;
   assign wbDataL  = r_wb_l;
   assign wbDataH  = r_wb_h;
   assign credits  = r_credits;

endmodule

// File: tb/tb_mult_wb_scheduler.sv
// Scoreboard bench for mult_wb_scheduler: directed MUL vectors, an ALU stream and a 4-stage multiplier model.
module tb_mult_wb_scheduler;

   localparam int D = 4;
`ifdef MULT_WB_BYPASS_EN
   localparam int ExpLat = 5;
`else
   localparam int ExpLat = 6;
`endif

   typedef struct packed {
      logic [3:0]  rob;
      logic [4:0]  dst;
      logic [31:0] h;
      logic [31:0] l;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        issValid = 1'b0;
   logic        issReady;
   logic [6:0]  issOpcode = 7'h33;
   logic [3:0]  issRobIdx = '0;
   logic [4:0]  issDstReg = '0;
   logic [31:0] issData1 = '0;
   logic [31:0] issData2 = '0;
   logic [6:0]  mulOpcode;
   logic [3:0]  mulRobIdx;
   logic [4:0]  mulDstReg;
   logic [31:0] mulData1;
   logic [31:0] mulData2;
   logic        mulClear;
   logic [6:0]  mulOpcodeRes;
   logic [3:0]  mulRobIdxRes;
   logic [4:0]  mulDstRegRes;
   logic [31:0] mulResH;
   logic [31:0] mulResL;
   logic        aluValid = 1'b0;
   logic [3:0]  aluRobIdx = '0;
   logic [4:0]  aluDstReg = '0;
   logic [31:0] aluData = '0;
   logic        aluGrant;
   logic        wbValid;
   logic        wbSrc;
   logic [3:0]  wbRobIdx;
   logic [4:0]  wbDstReg;
   logic [31:0] wbDataL;
   logic [31:0] wbDataH;
   logic [2:0]  credits;

   int  n_checks = 0;
   int  n_pass = 0;
   wb_t exp_mul[$];
   wb_t exp_alu[$];
   bit  alu_en = 1'b0;
   int  alu_seq = 0;

   always #5 clk = ~clk;

   mult_wb_scheduler dut (
      .clk(clk), .rst(rst), .clear(clear),
      .issValid(issValid), .issReady(issReady), .issOpcode(issOpcode),
      .issRobIdx(issRobIdx), .issDstReg(issDstReg), .issData1(issData1), .issData2(issData2),
      .mulOpcode(mulOpcode), .mulRobIdx(mulRobIdx), .mulDstReg(mulDstReg),
      .mulData1(mulData1), .mulData2(mulData2), .mulClear(mulClear),
      .mulOpcodeRes(mulOpcodeRes), .mulRobIdxRes(mulRobIdxRes), .mulDstRegRes(mulDstRegRes),
      .mulResH(mulResH), .mulResL(mulResL),
      .aluValid(aluValid), .aluRobIdx(aluRobIdx), .aluDstReg(aluDstReg), .aluData(aluData),
      .aluGrant(aluGrant),
      .wbValid(wbValid), .wbSrc(wbSrc), .wbRobIdx(wbRobIdx), .wbDstReg(wbDstReg),
      .wbDataL(wbDataL), .wbDataH(wbDataH), .credits(credits)
   );

   // 4-stage multiplier model, flushed by mulClear
   logic [6:0]  st_op  [4];
   logic [3:0]  st_rob [4];
   logic [4:0]  st_dst [4];
   logic [63:0] st_p   [4];

   always @(posedge clk) begin
      if (rst || mulClear) begin
         for (int i = 0; i < 4; i++) st_op[i] <= '0;
      end else begin
         st_op[0]  <= mulOpcode;
         st_rob[0] <= mulRobIdx;
         st_dst[0] <= mulDstReg;
         st_p[0]   <= 64'(mulData1) * 64'(mulData2);
         for (int i = 1; i < 4; i++) begin
            st_op[i]  <= st_op[i-1];
            st_rob[i] <= st_rob[i-1];
            st_dst[i] <= st_dst[i-1];
            st_p[i]   <= st_p[i-1];
         end
      end
   end

   assign mulOpcodeRes = st_op[3];
   assign mulRobIdxRes = st_rob[3];
   assign mulDstRegRes = st_dst[3];
   assign mulResH      = st_p[3][63:32];
   assign mulResL      = st_p[3][31:0];

   task automatic chk(input bit ok, input string name, input logic [127:0] act,
                      input logic [127:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   // ALU result stream
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (alu_en) begin
            aluValid  = 1'b1;
            aluRobIdx = 4'(alu_seq);
            aluDstReg = 5'(alu_seq + 7);
            aluData   = 32'hA5A5_0000 | 32'(alu_seq);
         end else begin
            aluValid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && aluValid && aluGrant) begin
         exp_alu.push_back('{rob: aluRobIdx, dst: aluDstReg, h: 32'h0, l: aluData});
         alu_seq++;
      end
   end

   // Monitor: scoreboard pops, round-robin fairness and the credit invariant
   int outstanding = 0;
   bit prev_wb_mul = 1'b0;
   bit alu_h1 = 1'b0;
   bit alu_h2 = 1'b0;

   always @(negedge clk) begin : monitor
      wb_t act;
      wb_t e;
      if (rst) begin
         outstanding = 0;
         prev_wb_mul = 1'b0;
         alu_h1 = 1'b0;
         alu_h2 = 1'b0;
      end else begin
         act = '{rob: wbRobIdx, dst: wbDstReg, h: wbDataH, l: wbDataL};
         if (wbValid) begin
            if (wbSrc) begin
               outstanding--;
               if (exp_mul.size() == 0) begin
                  chk(1'b0, "unexpected_mul_wb", 128'(act), 128'(0));
               end else begin
                  e = exp_mul.pop_front();
                  chk(act == e, "mul_wb", 128'(act), 128'(e));
               end
            end else begin
               if (exp_alu.size() == 0) begin
                  chk(1'b0, "unexpected_alu_wb", 128'(act), 128'(0));
               end else begin
                  e = exp_alu.pop_front();
                  chk(act == e, "alu_wb", 128'(act), 128'(e));
               end
            end
            if (prev_wb_mul && alu_h1 && alu_h2) begin
               chk(!wbSrc, "rr_alternation", 128'(wbSrc), 128'(0));
            end
         end
         chk(int'(credits) == D - outstanding, "credit_invariant", 128'(credits),
             128'(D - outstanding));
         if (issValid && issReady) outstanding++;
         if (clear) outstanding = 0;
         prev_wb_mul = wbValid && wbSrc;
         alu_h2 = alu_h1;
         alu_h1 = aluValid && !clear;
      end
   end

   task automatic issue_mul(input logic [31:0] a, input logic [31:0] b, input logic [3:0] rob,
                            input logic [4:0] dst, input logic [31:0] eh, input logic [31:0] el);
      bit ok = 1'b0;
      int n = 0;
      issOpcode = 7'h33;
      issData1  = a;
      issData2  = b;
      issRobIdx = rob;
      issDstReg = dst;
      issValid  = 1'b1;
      do begin
         @(negedge clk);
         ok = issReady;
         @(posedge clk);
         #1;
         n++;
      end while (!ok && n < 100);
      issValid = 1'b0;
      if (ok) exp_mul.push_back('{rob: rob, dst: dst, h: eh, l: el});
      else chk(1'b0, "issue_timeout", 128'(n), 128'(0));
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_mul.size() != 0 || exp_alu.size() != 0) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(exp_mul.size() == 0 && exp_alu.size() == 0, name,
          128'(exp_mul.size() + exp_alu.size()), 128'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k;
      // Reset with an offered issue
      issValid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk(issReady == 1'b0, "reset_issReady", 128'(issReady), 128'(0));
      chk(wbValid == 1'b0, "reset_wbValid", 128'(wbValid), 128'(0));
      chk(credits == 3'd4, "reset_credits", 128'(credits), 128'(4));
      chk(mulOpcode == 7'd0, "reset_mulOpcode", 128'(mulOpcode), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      issValid = 1'b0;
      @(negedge clk);
      chk(issReady == 1'b1, "release_issReady", 128'(issReady), 128'(1));
      @(posedge clk);
      #1;

      // Single MUL latency
      issue_mul(32'd7, 32'd9, 4'd1, 5'd3, 32'd0, 32'd63);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!wbValid && k < 30);
      chk(k == ExpLat, "single_latency", 128'(k), 128'(ExpLat));
      chk(wbSrc == 1'b1 && wbDataL == 32'd63 && wbDataH == 32'd0, "single_data",
          128'({wbSrc, wbDataH, wbDataL}), 128'({1'b1, 32'd0, 32'd63}));
      chk(credits == 3'd4, "single_credits_back", 128'(credits), 128'(4));
      @(posedge clk);
      #1;

      // Six back-to-back MULs against a continuous ALU stream
      alu_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      issue_mul(32'd3, 32'd5, 4'd2, 5'd4, 32'h0, 32'd15);
      issue_mul(32'h0001_0000, 32'h0001_0000, 4'd3, 5'd5, 32'h1, 32'h0);
      issue_mul(32'h1234_5678, 32'd2, 4'd4, 5'd6, 32'h0, 32'h2468_ACF0);
      issue_mul(32'h8000_0000, 32'd4, 4'd5, 5'd7, 32'h2, 32'h0);
      @(negedge clk);
      chk(issReady == 1'b0 && credits == 3'd0, "credits_exhausted",
          128'({issReady, credits}), 128'(0));
      @(posedge clk);
      #1;
      issue_mul(32'd100, 32'd1000, 4'd6, 5'd8, 32'h0, 32'h0001_86A0);
      issue_mul(32'hFFFF_FFFF, 32'd2, 4'd7, 5'd9, 32'h1, 32'hFFFF_FFFE);
      alu_en = 1'b0;
      wait_drain("b2b_all_written");

      // Largest operands
      issue_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8, 5'd10, 32'hFFFF_FFFE, 32'h0000_0001);
      wait_drain("max_product_written");

      // Flush with products in flight and buffered
      issue_mul(32'd2, 32'd3, 4'd9, 5'd11, 32'h0, 32'd6);
      issue_mul(32'd4, 32'd5, 4'd10, 5'd12, 32'h0, 32'd20);
      issue_mul(32'd6, 32'd7, 4'd11, 5'd13, 32'h0, 32'd42);
      issue_mul(32'd8, 32'd9, 4'd12, 5'd14, 32'h0, 32'd72);
      @(posedge clk);
      #1;
      clear = 1'b1;
      issValid = 1'b1;
      @(negedge clk);
      chk(mulClear == 1'b1, "clear_mulClear", 128'(mulClear), 128'(1));
      chk(issReady == 1'b0, "clear_issue_rejected", 128'(issReady), 128'(0));
      @(posedge clk);
      #1;
      clear = 1'b0;
      issValid = 1'b0;
      exp_mul.delete();
      @(negedge clk);
      chk(credits == 3'd4, "clear_credits", 128'(credits), 128'(4));
      chk(wbValid == 1'b0, "clear_wbValid", 128'(wbValid), 128'(0));
      repeat (12) @(negedge clk);
      @(posedge clk);
      #1;

      // Recovery after flush
      issue_mul(32'h0000_FFFF, 32'h0000_FFFF, 4'd13, 5'd15, 32'h0, 32'hFFFE_0001);
      wait_drain("post_clear_written");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by time limit, required finish");
      $fatal(1);
   end

endmodule
